// File: rtl/addr_mode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addr_mode_pkg
// Description : Shared addressing-mode codes, sequencer state codes and
//               start-to-done latencies for the 6502 EA sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package addr_mode_pkg;

    // Operand addressing modes; codes 5-7 are reserved and treated as ZP
    typedef enum logic [2:0] {
        MODE_ZP   = 3'd0,
        MODE_ZPX  = 3'd1,
        MODE_ABS  = 3'd2,
        MODE_ABSX = 3'd3,
        MODE_IND  = 3'd4
    } mode_t;

    // Sequencer states
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH_L = 3'd1;
    localparam logic [2:0] S_FETCH_H = 3'd2;
    localparam logic [2:0] S_FIXUP   = 3'd3;
    localparam logic [2:0] S_IND_L   = 3'd4;
    localparam logic [2:0] S_IND_H   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    // Cycles from the start edge to the done-high cycle with ready held high
    localparam int LAT_ZP       = 2;
    localparam int LAT_ZPX      = 2;
    localparam int LAT_ABS      = 3;
    localparam int LAT_ABSX     = 3;
    localparam int LAT_ABSX_FIX = 4;
    localparam int LAT_IND      = 5;

endpackage : addr_mode_pkg
`default_nettype wire

// File: rtl/ea_reg.sv
`default_nettype none
// ============================================================================
// Module      : ea_reg
// Description : 16-bit effective-address register with independent low/high
//               byte loads and a high-byte carry increment for page fix-up.
// Revision    : 1.0 - initial release
// ============================================================================
module ea_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_l,
    input  logic        load_h,
    input  logic        inc_h,
    input  logic        carry,
    input  logic [7:0]  d_l,
    input  logic [7:0]  d_h,
    output logic [15:0] q
);

    // Byte-wise load; the increment has priority over a high-byte load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 16'h0000;
        end else begin
            if (load_l) begin
                q[7:0] <= d_l;
            end
            if (inc_h) begin
                q[15:8] <= q[15:8] + {7'd0, carry};
            end else if (load_h) begin
                q[15:8] <= d_h;
            end
        end
    end

endmodule : ea_reg
`default_nettype wire

// File: rtl/addr_mode_seq.sv
`default_nettype none
// ============================================================================
// Module      : addr_mode_seq
// Description : 6502 effective-address sequencer: operand fetch, indexed add
//               with page-cross fix-up, and JMP-indirect pointer reads.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_mode_seq
    import addr_mode_pkg::*;
#(
    parameter bit NMOS_JMP_BUG = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic [7:0]  index,
    input  logic        force_fix,
    input  logic        ready,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic        pc_inc,
    output logic        bus_sel,
    output logic [15:0] bus_addr,
    output logic [15:0] ea,
    output logic        page_cross,
    output logic        done
);

    logic [2:0]  r_state;
    mode_t       r_mode;
    logic [7:0]  r_idx;
    logic        r_fix;
    logic [15:0] r_ptr;
    logic        r_page_cross;

    logic        w_ld_l;
    logic        w_ld_h;
    logic        w_inc_h;
    logic [7:0]  w_d_l;
    logic [7:0]  w_d_h;
    logic [7:0]  w_idx_eff;
    logic [8:0]  w_sum;

    // ABS shares the ABSX adder with a zero index so its carry is always 0
    assign w_idx_eff = (r_mode == MODE_ABSX) ? r_idx : 8'h00;
    assign w_sum     = {1'b0, data_in} + {1'b0, w_idx_eff};

    assign busy       = (r_state != S_IDLE);
    assign pc_inc     = (r_state == S_FETCH_L) || (r_state == S_FETCH_H);
    assign bus_sel    = (r_state == S_IND_L) || (r_state == S_IND_H);
    assign done       = (r_state == S_DONE);
    assign page_cross = r_page_cross;

    // Pointer address for the indirect reads; NMOS parts wrap within the page
    always_comb begin
        bus_addr = 16'h0000;
        if (r_state == S_IND_L) begin
            bus_addr = r_ptr;
        end else if (r_state == S_IND_H) begin
            if (NMOS_JMP_BUG) begin
                bus_addr = {r_ptr[15:8], r_ptr[7:0] + 8'd1};
            end else begin
                bus_addr = r_ptr + 16'd1;
            end
        end
    end

    // EA register byte enables, all qualified by ready
    always_comb begin
        w_ld_l  = 1'b0;
        w_ld_h  = 1'b0;
        w_inc_h = 1'b0;
        w_d_l   = data_in;
        w_d_h   = data_in;
        if (ready) begin
            case (r_state)
                S_FETCH_L: begin
                    case (r_mode)
                        MODE_ZPX: begin
                            w_ld_l = 1'b1;
                            w_d_l  = data_in + r_idx;
                            w_ld_h = 1'b1;
                            w_d_h  = 8'h00;
                        end
                        MODE_ABS, MODE_ABSX: begin
                            w_ld_l = 1'b1;
                            w_d_l  = w_sum[7:0];
                        end
                        MODE_IND: begin
                            w_ld_l = 1'b0;
                        end
                        default: begin
                            w_ld_l = 1'b1;
                            w_ld_h = 1'b1;
                            w_d_h  = 8'h00;
                        end
                    endcase
                end
                S_FETCH_H: begin
                    w_ld_h = (r_mode == MODE_ABS) || (r_mode == MODE_ABSX);
                end
                S_FIXUP: begin
                    w_inc_h = 1'b1;
                end
                S_IND_L: begin
                    w_ld_l = 1'b1;
                end
                S_IND_H: begin
                    w_ld_h = 1'b1;
                end
                default: begin
                    w_ld_l = 1'b0;
                end
            endcase
        end
    end

    ea_reg u_ea_reg (
        .clk    (clk),
        .rst_n  (reset_n),
        .load_l (w_ld_l),
        .load_h (w_ld_h),
        .inc_h  (w_inc_h),
        .carry  (r_page_cross),
        .d_l    (w_d_l),
        .d_h    (w_d_h),
        .q      (ea)
    );

    // State sequencing plus mode/index/pointer/carry capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_mode       <= MODE_ZP;
            r_idx        <= 8'h00;
            r_fix        <= 1'b0;
            r_ptr        <= 16'h0000;
            r_page_cross <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode       <= (mode > MODE_IND) ? MODE_ZP : mode_t'(mode);
                        r_idx        <= index;
                        r_fix        <= force_fix;
                        r_page_cross <= 1'b0;
                        r_state      <= S_FETCH_L;
                    end
                end
                S_FETCH_L: begin
                    if (ready) begin
                        case (r_mode)
                            MODE_ABS, MODE_ABSX: begin
                                r_page_cross <= w_sum[8];
                                r_state      <= S_FETCH_H;
                            end
                            MODE_IND: begin
                                r_ptr[7:0] <= data_in;
                                r_state    <= S_FETCH_H;
                            end
                            default: r_state <= S_DONE;
                        endcase
                    end
                end
                S_FETCH_H: begin
                    if (ready) begin
                        if (r_mode == MODE_IND) begin
                            r_ptr[15:8] <= data_in;
                            r_state     <= S_IND_L;
                        end else if ((r_mode == MODE_ABSX) && (r_page_cross || r_fix)) begin
                            r_state <= S_FIXUP;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FIXUP: if (ready) r_state <= S_DONE;
                S_IND_L: if (ready) r_state <= S_IND_H;
                S_IND_H: if (ready) r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule : addr_mode_seq
`default_nettype wire

// File: tb/tb_addr_mode_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_mode_seq
// Description : Directed self-checking bench for addr_mode_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_mode_seq;
    import addr_mode_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  mode;
    logic [7:0]  index;
    logic        force_fix;
    logic        ready;
    logic [7:0]  data_in;

    logic        busy, pc_inc, bus_sel, page_cross, done;
    logic [15:0] bus_addr, ea;
    logic        busy_nb, pc_inc_nb, bus_sel_nb, page_cross_nb, done_nb;
    logic [15:0] bus_addr_nb, ea_nb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addr_mode_seq #(.NMOS_JMP_BUG(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .index(index),
        .force_fix(force_fix), .ready(ready), .data_in(data_in), .busy(busy),
        .pc_inc(pc_inc), .bus_sel(bus_sel), .bus_addr(bus_addr), .ea(ea),
        .page_cross(page_cross), .done(done)
    );

    addr_mode_seq #(.NMOS_JMP_BUG(1'b0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .index(index),
        .force_fix(force_fix), .ready(ready), .data_in(data_in), .busy(busy_nb),
        .pc_inc(pc_inc_nb), .bus_sel(bus_sel_nb), .bus_addr(bus_addr_nb), .ea(ea_nb),
        .page_cross(page_cross_nb), .done(done_nb)
    );

    typedef struct {
        logic [2:0]  mode;
        logic [7:0]  idx;
        logic        ff;
        logic [7:0]  b0, b1, m0, m1;
        logic [15:0] a1, a2, a2nb;
        logic [15:0] ea;
        logic        pc;
        int          lat;
        int          npc;
        int          nbs;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one sequence from IDLE with ready=1, act as PC stream and memory
    task automatic run_vec(input vec_t v, input int id);
        int got  = 0;
        int npc  = 0;
        int nbs  = 0;
        start     = 1'b1;
        mode      = v.mode;
        index     = v.idx;
        force_fix = v.ff;
        ready     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (done) begin
                got = n;
                break;
            end
            if (pc_inc) begin
                data_in = (npc == 0) ? v.b0 : v.b1;
                npc++;
            end else if (bus_sel) begin
                if (nbs == 0) begin
                    chk($sformatf("v%0d ind_addr_lo", id), {16'h0, bus_addr}, {16'h0, v.a1});
                end else begin
                    chk($sformatf("v%0d ind_addr_hi", id), {16'h0, bus_addr}, {16'h0, v.a2});
                    chk($sformatf("v%0d ind_addr_hi_cmos", id), {16'h0, bus_addr_nb}, {16'h0, v.a2nb});
                end
                data_in = (bus_addr == v.a1) ? v.m0 : (bus_addr == v.a2) ? v.m1 : 8'hEE;
                nbs++;
            end else begin
                data_in = 8'hA5;
            end
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d latency", id), got, v.lat);
        chk($sformatf("v%0d ea", id), {16'h0, ea}, {16'h0, v.ea});
        chk($sformatf("v%0d page_cross", id), {31'h0, page_cross}, {31'h0, v.pc});
        chk($sformatf("v%0d pc_inc_cycles", id), npc, v.npc);
        chk($sformatf("v%0d bus_sel_cycles", id), nbs, v.nbs);
        @(posedge clk); #1;
        chk($sformatf("v%0d idle_after_done", id), {31'h0, busy}, 32'h0);
    endtask

    initial begin
        //          mode       idx    ff    b0     b1     m0     m1     a1        a2        a2nb      ea        pc    lat           npc nbs
        vecs[0] = '{MODE_ABS,  8'h00, 1'b0, 8'h34, 8'h12, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 1'b0, LAT_ABS,      2,  0};
        vecs[1] = '{MODE_ABSX, 8'hF0, 1'b0, 8'h20, 8'h12, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h1310, 1'b1, LAT_ABSX_FIX, 2,  0};
        vecs[2] = '{MODE_ABSX, 8'hF0, 1'b0, 8'h20, 8'hFF, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 1'b1, LAT_ABSX_FIX, 2,  0};
        vecs[3] = '{MODE_ABSX, 8'h05, 1'b1, 8'h10, 8'h40, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h4015, 1'b0, LAT_ABSX_FIX, 2,  0};
        vecs[4] = '{MODE_ZPX,  8'h20, 1'b0, 8'hF0, 8'h99, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 1'b0, LAT_ZPX,      1,  0};
        vecs[5] = '{MODE_IND,  8'h00, 1'b0, 8'hFF, 8'h30, 8'h80, 8'h50, 16'h30FF, 16'h3000, 16'h3100, 16'h5080, 1'b0, LAT_IND,      2,  2};
        vecs[6] = '{MODE_ZP,   8'h55, 1'b1, 8'h7F, 8'h99, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h007F, 1'b0, LAT_ZP,       1,  0};
        vecs[7] = '{MODE_ABSX, 8'h05, 1'b0, 8'h10, 8'h40, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h4015, 1'b0, LAT_ABSX,     2,  0};
        vecs[8] = '{3'd6,      8'h10, 1'b0, 8'h44, 8'h99, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0044, 1'b0, LAT_ZP,       1,  0};
        vecs[9] = '{MODE_ABS,  8'hF0, 1'b1, 8'h20, 8'h12, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h1220, 1'b0, LAT_ABS,      2,  0};

        reset_n = 1'b0; start = 1'b0; mode = 3'd0; index = 8'h00;
        force_fix = 1'b0; ready = 1'b1; data_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst done", {31'h0, done}, 32'h0);
        chk("rst strobes", {29'h0, pc_inc, bus_sel, page_cross}, 32'h0);
        chk("rst ea_bus", {ea, bus_addr}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // Ready stall in FETCH_H of ABS, with a stray start while busy
        start = 1'b1; mode = MODE_ABS; index = 8'h00; force_fix = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; data_in = 8'h34;
        @(posedge clk); #1;
        ready = 1'b0; data_in = 8'h12;
        start = 1'b1; mode = MODE_ZP;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d hold", k), {28'h0, pc_inc, busy, done, bus_sel}, {28'h0, 4'b1100});
            chk($sformatf("stall%0d ea_lo", k), {24'h0, ea[7:0]}, 32'h34);
        end
        start = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        chk("stall done", {31'h0, done}, 32'h1);
        chk("stall ea", {16'h0, ea}, 32'h1234);
        @(posedge clk); #1;
        chk("stall idle", {30'h0, busy, done}, 32'h0);

        // Asynchronous reset while in IND_L
        start = 1'b1; mode = MODE_IND;
        @(posedge clk); #1;
        start = 1'b0; data_in = 8'hFF;
        @(posedge clk); #1;
        data_in = 8'h30;
        @(posedge clk); #1;
        chk("ind_l reached", {31'h0, bus_sel}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst busy", {31'h0, busy}, 32'h0);
        chk("async rst outs", {ea, bus_addr}, 32'h0);
        chk("async rst strobes", {28'h0, pc_inc, bus_sel, done, page_cross}, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[6], 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute runtime guard
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule : tb_addr_mode_seq
`default_nettype wire

// File: doc/addr_mode_seq.md
Name: addr_mode_seq

Overview:
- Sequences the 6502 effective-address (EA) register for operand addressing modes.
- Steps through operand-byte fetches, indexed add with page-cross fix-up, and JMP-indirect pointer reads.
- Presents a finished 16-bit EA to the core.
- Sits between the instruction decoder, which issues start and mode, and the memory bus mux, which it drives through bus_sel, bus_addr and pc_inc.

Parameters:
- NMOS_JMP_BUG, 1: 1 = indirect high-byte read wraps within the pointer's page; 0 = full 16-bit pointer+1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin sequence; sampled only in IDLE
- mode  in  3  addressing mode code (package enum)
- index  in  8  X/Y value; captured at start
- force_fix  in  1  always take the fix-up cycle (stores/RMW); captured at start
- ready  in  1  bus ready (RDY); a state advances only on an edge with ready=1
- data_in  in  8  memory read data; valid on an edge with ready=1
- busy  out  1  high in every state except IDLE
- pc_inc  out  1  high in FETCH_L/FETCH_H: operand byte consumed from the PC stream
- bus_sel  out  1  0 = PC drives bus; 1 = bus_addr drives bus (IND_L/IND_H only)
- bus_addr  out  16  pointer address during IND_L/IND_H; 0 otherwise
- ea  out  16  effective address; valid while done=1, held until the next start
- page_cross  out  1  indexed low-byte add carried; valid with done
- done  out  1  one-cycle pulse, state DONE

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - ea=0, ptr=0, idx=0, fix=0, page_cross=0.
  - All strobes low.
- Modes:
  - ZP=0: ea={00,b0}.
  - ZPX=1: ea={00,(b0+idx)[7:0]}, wraps within page 0, page_cross=0.
  - ABS=2: ea={b1,b0}.
  - ABSX=3: ea={b1,b0}+idx.
  - IND=4: ptr={b1,b0}, ea={mem[ptr+1'],mem[ptr]}.
  - Codes 5-7 are reserved and behave as ZP.
- IDLE:
  - start=1 captures mode, idx and force_fix, then goes to FETCH_L.
  - start is ignored when not in IDLE. start is not accepted while in DONE.
- FETCH_L (pc_inc=1), on a ready edge:
  - ZP: ea_l=data_in, ea_h=0, go to DONE.
  - ZPX: ea_l=data_in+idx (8-bit), ea_h=0, go to DONE.
  - ABS/ABSX: {c,ea_l}=data_in+idx (idx treated as 0 for ABS), page_cross=c, go to FETCH_H.
  - IND: ptr_l=data_in, go to FETCH_H.
- FETCH_H (pc_inc=1), on a ready edge:
  - ABS/ABSX: ea_h=data_in. Go to FIXUP if ABSX and (page_cross or force_fix); otherwise go to DONE.
  - IND: ptr_h=data_in, go to IND_L.
- FIXUP: ea_h=ea_h+page_cross (8-bit, wraps FF->00), go to DONE.
- IND_L:
  - bus_sel=1, bus_addr=ptr.
  - On a ready edge: ea_l=data_in, go to IND_H.
- IND_H:
  - bus_sel=1.
  - bus_addr={ptr_h,ptr_l+1}; if NMOS_JMP_BUG=0, bus_addr=ptr+1 (16-bit).
  - On a ready edge: ea_h=data_in, go to DONE.
- DONE: done=1 for one cycle, unconditionally; ready is ignored. Then go to IDLE.
- ready=0: state, ea and ptr hold; combinational strobes (pc_inc, bus_sel, bus_addr) stay asserted for the held state.
- Latency, start edge to done-high cycle, with ready=1 throughout:
  - ZP/ZPX: 2.
  - ABS: 3.
  - ABSX: 3, or 4 with page cross or force_fix.
  - IND: 5.
- Index add is unsigned 8-bit. The carry goes only to page_cross and is applied in FIXUP, never directly in FETCH_H.
- With ABSX, force_fix=1 and no carry: FIXUP leaves ea_h unchanged.
- Reset asserted mid-sequence: immediate IDLE with all registers zeroed. The first start after reset release behaves normally.

Decomposition:
- Shared package addr_mode_pkg holds:
  - the mode enum (MODE_ZP..MODE_IND, 3-bit);
  - the state enum (IDLE, FETCH_L, FETCH_H, FIXUP, IND_L, IND_H, DONE);
  - the latency constants used by the bench.
- One natural sub-module, ea_reg:
  - 16-bit register with separate low/high byte load enables, async active-low reset, and high-byte +carry increment.
  - Clocked on clk with enables, not strobe-clocked.
  - The FSM drives its enables.

Test Plan:
- ABS, data bytes 34,12, ready=1 -> pc_inc high 2 cycles, done in cycle 3, ea=1234, page_cross=0.
- ABSX, idx=F0, bytes 20,12 -> FIXUP taken, done in cycle 4, ea=1310, page_cross=1. Repeat with bytes 20,FF -> ea=0010 (wrap).
- ABSX, idx=05, bytes 10,40, force_fix=1 -> done in cycle 4, ea=4015, page_cross=0.
- ZPX, idx=20, byte F0 -> done in cycle 2, ea=0010. IND, ptr bytes FF,30, NMOS_JMP_BUG=1 -> bus_addr 30FF then 3000, mem 30FF=80, 3000=50 -> ea=5080; with NMOS_JMP_BUG=0 -> second bus_addr=3100.
- ready=0 for 3 cycles during FETCH_H of ABS -> state, pc_inc and ea held, done delayed exactly 3 cycles. start pulsed while busy -> ignored.
- reset_n low during IND_L -> outputs zero asynchronously, busy=0. After release, ZP start with byte 7F -> ea=007F in cycle 2.
